uart_secded_rx_fifo: RTL and testbench
======================================

Name: uart_secded_rx_fifo

Overview:
Parametrised next-generation UART receiver with per-nibble extended Hamming(8,4) SEC-DED decoding. Each DATA_SIZE-bit word arrives as DATA_SIZE/4 UART codeword bytes. The block decodes each codeword, corrects single errors, flags double errors, and assembles the nibbles into a word. Each word is pushed with its error flags into a show-ahead FIFO. It sits between the rx pin and the host-side reader, and adds framing, inter-byte-gap and overrun detection plus saturating error counters.

Parameters:
DATA_SIZE, 8, payload word width; multiple of 4, range 4..32; NUM_NIB = DATA_SIZE/4 codewords per word
FIFO_DEPTH, 16, FIFO entries; power of 2
SYS_FREQ, 50000000, clock frequency in Hz
BAUD_RATE, 115200, line rate
SAMPLE, 16, oversampling ticks per bit
BAUD_DVSR, (SYS_FREQ*2+SAMPLE*BAUD_RATE)/(2*SAMPLE*BAUD_RATE), clocks per tick (rounded)
LSN_FIRST, 1, 1 = first codeword carries the least-significant nibble; 0 = most-significant nibble first
GAP_BITS, 20, idle bit-times allowed between codewords of one word

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
rx  in  1  asynchronous serial input, idle high
rd_en  in  1  pop request
clr_status  in  1  clears sticky flags and counters
rd_data  out  DATA_SIZE  head-of-FIFO word
rd_corrected  out  1  head word had at least one corrected codeword
rd_dbl_err  out  1  head word had at least one uncorrectable codeword
fifo_empty  out  1  FIFO empty
fifo_full  out  1  FIFO full
fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy
overrun  out  1  sticky: a word was dropped because the FIFO was full
frame_err  out  1  sticky: a stop bit was sampled low
frag_err  out  1  sticky: a partial word was discarded on gap timeout
cnt_single  out  16  saturating count of corrected codewords
cnt_double  out  16  saturating count of double-error codewords

Behaviour:
- Reset (reset_n=0 at a clk edge) clears all state:
  - fifo_empty=1, fifo_full=0, fifo_count=0.
  - rd_data, rd_corrected, rd_dbl_err = 0.
  - All sticky flags and counters = 0.
  - FSM returns to IDLE.
  - Reset mid-frame or mid-word discards the partial data.
- rx passes through a 2-flop synchronizer, whose flops reset to 1.
- Tick generator: counter 0..BAUD_DVSR-1 produces a 1-cycle s_tick pulse and free-runs.
- Receive FSM:
  - IDLE: a falling edge on the synchronized rx moves to START with tick count 0.
  - START: at tick 7, rx=1 returns to IDLE (glitch); otherwise go to DATA.
  - DATA: sample every 16 ticks, 8 bits, LSB first.
  - STOP: sample after 16 ticks. rx=0 sets frame_err, discards the byte, resets the nibble index and flags to 0, and returns to IDLE. rx=1 produces a byte_done pulse and returns to IDLE.
- Codeword layout c[7:0]:
  - c0=p1, c1=p2, c2=d0, c3=p4, c4=d1, c5=d2, c6=d3, c7=overall parity of c[6:0].
  - s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s4=c3^c4^c5^c6; s={s4,s2,s1}; P=^c[7:0].
- Decode:
  - s=0, P=0: clean.
  - s!=0, P=1: flip c[s-1], then count as corrected.
  - s=0, P=1: p0 error; data is taken as-is and counted as corrected.
  - s!=0, P=0: double error; the raw nibble is used unchanged and the word's dbl flag is set.
- Assembly:
  - Nibble index 0..NUM_NIB-1. With LSN_FIRST=1, index k fills bits [4k+3:4k]; with LSN_FIRST=0, the order is mirrored.
  - Flags are OR-accumulated across the word.
  - On the last byte_done, push {dbl, corr, word} one clock later, then clear the index and flags.
- Gap timeout: with index>0, if FSM stays IDLE for GAP_BITS*16 ticks, discard the partial word, set frag_err, reset index to 0.
- FIFO (first-word fall-through):
  - Outputs are valid whenever fifo_empty=0.
  - rd_en pops on the same edge; rd_en while empty is ignored.
  - Push while full with no pop: word dropped, overrun set.
  - Push and pop in the same cycle when full: both occur, count unchanged.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters: increment once per affected codeword and saturate at 16'hFFFF.
- clr_status: clears sticky flags and counters on the next edge. If an event occurs in the same cycle, the event wins (flag ends at 1, counter ends at 1).

Test Plan:
- Clean word, defaults: bytes 0x66 then 0xE1 -> one entry rd_data=0xCD, rd_corrected=0, rd_dbl_err=0, cnt_single=0, cnt_double=0.
- Single and parity-bit errors: bytes 0x62,0xE1 then 0xE6,0xE1 -> two entries 0xCD, each with rd_corrected=1; cnt_single=2.
- Double error: bytes 0x65,0xE1 -> entry pushed with rd_dbl_err=1, cnt_double=1, rd_data[7:4]=0xC.
- Framing and recovery:
  - Send 0x66 with stop bit 0 -> frame_err=1, no push.
  - Then 0x66,0xE1 -> 0xCD.
  - clr_status -> frame_err=0.
- Overflow: 17 words of 0x00 then 0xFF pairs (data 0xF0) with no reads -> fifo_full=1, fifo_count=16, overrun=1. Then 16 pops return 0xF0 in order and fifo_empty=1. A pop with push in the same cycle while full keeps the count at 16.
- Gap timeout and reset:
  - Send 0x66, idle 25 bit-times -> frag_err=1, no push.
  - Then 0x00,0xFF -> 0xF0.
  - Assert reset_n=0 mid-byte -> all outputs return to reset values and no entry appears.

Source files
------------

// File: rtl/uart_secded_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_secded_rx_fifo                                             |
// | Purpose  : UART receiver decoding extended Hamming(8,4) codewords into     |
// |            DATA_SIZE-bit words, queued with error flags in a show-ahead    |
// |            FIFO. Framing, gap-timeout and overrun flags plus counters.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_secded_rx_fifo #(
  parameter int DATA_SIZE  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int SYS_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int SAMPLE     = 16,
  parameter int BAUD_DVSR  = (SYS_FREQ*2 + SAMPLE*BAUD_RATE) / (2*SAMPLE*BAUD_RATE),
  parameter int LSN_FIRST  = 1,
  parameter int GAP_BITS   = 20
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_status,
  output logic [DATA_SIZE-1:0]          rd_data,
  output logic                          rd_corrected,
  output logic                          rd_dbl_err,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          frame_err,
  output logic                          frag_err,
  output logic [15:0]                   cnt_single,
  output logic [15:0]                   cnt_double
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int c_NUM_NIB = DATA_SIZE / 4;
  localparam int c_NIW     = (c_NUM_NIB > 1) ? $clog2(c_NUM_NIB) : 1;
  localparam logic [c_NIW-1:0] c_LAST_IDX = c_NIW'(c_NUM_NIB - 1);

  localparam int c_TW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
  localparam logic [c_TW-1:0] c_DVSR_MAX = c_TW'(BAUD_DVSR - 1);

  localparam int c_SW = $clog2(SAMPLE);
  localparam logic [c_SW-1:0] c_S_MID  = c_SW'(SAMPLE/2 - 1);
  localparam logic [c_SW-1:0] c_S_LAST = c_SW'(SAMPLE - 1);

  localparam int c_GW = $clog2(GAP_BITS*SAMPLE);
  localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_BITS*SAMPLE - 1);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  // ---------------------------------------------------------------------------
  // Synchronizer and oversampling tick
  // ---------------------------------------------------------------------------
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [c_TW-1:0] tick_cnt_q;
  logic            w_s_tick;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign w_s_tick = (tick_cnt_q == c_DVSR_MAX);

  // Free-running divider producing one s_tick per BAUD_DVSR clocks.
  always_ff @(posedge clk) begin
    if (!reset_n)      tick_cnt_q <= '0;
    else if (w_s_tick) tick_cnt_q <= '0;
    else               tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [c_SW-1:0] s_cnt_q, s_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            byte_done_q, byte_done_d;
  logic            frame_evt_q, frame_evt_d;

  // Next-state logic: start-bit validation at mid-bit, then one sample per bit.
  always_comb begin
    state_d     = state_q;
    s_cnt_d     = s_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    byte_done_d = 1'b0;
    frame_evt_d = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = c_START;
          s_cnt_d = '0;
        end
      end
      c_START: begin
        if (w_s_tick) begin
          if (s_cnt_q == c_S_MID) begin
            s_cnt_d   = '0;
            bit_cnt_d = '0;
            state_d   = rx_sync_q ? c_IDLE : c_DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      c_DATA: begin
        if (w_s_tick) begin
          if (s_cnt_q == c_S_LAST) begin
            s_cnt_d = '0;
            shreg_d = {rx_sync_q, shreg_q[7:1]};
            if (bit_cnt_q == 3'd7) state_d = c_STOP;
            else                   bit_cnt_d = bit_cnt_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      c_STOP: begin
        if (w_s_tick) begin
          if (s_cnt_q == c_S_LAST) begin
            state_d = c_IDLE;
            if (rx_sync_q) byte_done_d = 1'b1;
            else           frame_evt_d = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= c_IDLE;
      s_cnt_q     <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      byte_done_q <= 1'b0;
      frame_evt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_cnt_q     <= s_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      byte_done_q <= byte_done_d;
      frame_evt_q <= frame_evt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // SEC-DED decode of the received codeword (shreg_q is stable on byte_done_q)
  // ---------------------------------------------------------------------------
  logic [2:0] w_syn;
  logic       w_par;
  logic [7:0] w_fixed;
  logic [3:0] w_nib;
  logic       w_corr, w_dbl;

  assign w_syn = {shreg_q[3] ^ shreg_q[4] ^ shreg_q[5] ^ shreg_q[6],
                  shreg_q[1] ^ shreg_q[2] ^ shreg_q[5] ^ shreg_q[6],
                  shreg_q[0] ^ shreg_q[2] ^ shreg_q[4] ^ shreg_q[6]};
  assign w_par = ^shreg_q;

  // Flip the bit the syndrome points at; only when overall parity confirms a
  // single error. A double error leaves the raw codeword untouched.
  always_comb begin
    w_fixed = shreg_q;
    if ((w_syn != 3'd0) && w_par) begin
      w_fixed[w_syn - 3'd1] = ~shreg_q[w_syn - 3'd1];
    end
  end

  assign w_nib  = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};
  assign w_corr = w_par;                       // single error or p0 error
  assign w_dbl  = (w_syn != 3'd0) && !w_par;

  // ---------------------------------------------------------------------------
  // Word assembly and gap timeout
  // ---------------------------------------------------------------------------
  logic [c_NIW-1:0]     nib_idx_q, nib_idx_d;
  logic [DATA_SIZE-1:0] word_q, word_d;
  logic                 acc_corr_q, acc_corr_d;
  logic                 acc_dbl_q, acc_dbl_d;
  logic                 push_q, push_d;
  logic [DATA_SIZE-1:0] push_word_q, push_word_d;
  logic                 push_corr_q, push_corr_d;
  logic                 push_dbl_q, push_dbl_d;
  logic [c_GW-1:0]      gap_cnt_q;
  logic [c_NIW-1:0]     w_pos;
  logic [DATA_SIZE-1:0] w_word_new;
  logic                 w_gap_armed, w_gap_hit, w_frag_evt;

  assign w_pos       = (LSN_FIRST != 0) ? nib_idx_q : (c_LAST_IDX - nib_idx_q);
  assign w_gap_armed = (state_q == c_IDLE) && (nib_idx_q != '0);
  assign w_gap_hit   = w_gap_armed && w_s_tick && (gap_cnt_q == c_GAP_LAST);

  // Partial word with the freshly decoded nibble merged into its slot.
  always_comb begin
    w_word_new = word_q;
    w_word_new[{w_pos, 2'b00} +: 4] = w_nib;
  end

  // Nibble accumulation; the completed word is staged for a push next clock.
  always_comb begin
    nib_idx_d   = nib_idx_q;
    word_d      = word_q;
    acc_corr_d  = acc_corr_q;
    acc_dbl_d   = acc_dbl_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    push_corr_d = push_corr_q;
    push_dbl_d  = push_dbl_q;
    w_frag_evt  = 1'b0;
    if (frame_evt_q) begin
      nib_idx_d  = '0;
      word_d     = '0;
      acc_corr_d = 1'b0;
      acc_dbl_d  = 1'b0;
    end else if (byte_done_q) begin
      if (nib_idx_q == c_LAST_IDX) begin
        push_d      = 1'b1;
        push_word_d = w_word_new;
        push_corr_d = acc_corr_q | w_corr;
        push_dbl_d  = acc_dbl_q | w_dbl;
        nib_idx_d   = '0;
        word_d      = '0;
        acc_corr_d  = 1'b0;
        acc_dbl_d   = 1'b0;
      end else begin
        nib_idx_d  = nib_idx_q + 1'b1;
        word_d     = w_word_new;
        acc_corr_d = acc_corr_q | w_corr;
        acc_dbl_d  = acc_dbl_q | w_dbl;
      end
    end else if (w_gap_hit) begin
      w_frag_evt = 1'b1;
      nib_idx_d  = '0;
      word_d     = '0;
      acc_corr_d = 1'b0;
      acc_dbl_d  = 1'b0;
    end
  end

  // Assembly and push-staging registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      nib_idx_q   <= '0;
      word_q      <= '0;
      acc_corr_q  <= 1'b0;
      acc_dbl_q   <= 1'b0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      push_corr_q <= 1'b0;
      push_dbl_q  <= 1'b0;
    end else begin
      nib_idx_q   <= nib_idx_d;
      word_q      <= word_d;
      acc_corr_q  <= acc_corr_d;
      acc_dbl_q   <= acc_dbl_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      push_corr_q <= push_corr_d;
      push_dbl_q  <= push_dbl_d;
    end
  end

  // Counts idle ticks while a word is half-assembled.
  always_ff @(posedge clk) begin
    if (!reset_n)                     gap_cnt_q <= '0;
    else if (!w_gap_armed || w_gap_hit) gap_cnt_q <= '0;
    else if (w_s_tick)                gap_cnt_q <= gap_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_SIZE+1:0] fifo_mem_q [FIFO_DEPTH];
  logic [c_AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [c_CW-1:0]      count_q;
  logic [DATA_SIZE+1:0] w_head;
  logic                 w_pop, w_push, w_ovr_evt;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == c_FULL_CNT);
  assign fifo_count = count_q;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push then.
  assign w_pop     = rd_en && !fifo_empty;
  assign w_push    = push_q && (!fifo_full || w_pop);
  assign w_ovr_evt = push_q && fifo_full && !w_pop;

  // Storage array; contents are masked by fifo_empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) fifo_mem_q[wr_ptr_q] <= {push_dbl_q, push_corr_q, push_word_q};
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign w_head       = fifo_mem_q[rd_ptr_q];
  assign rd_data      = fifo_empty ? '0 : w_head[DATA_SIZE-1:0];
  assign rd_corrected = fifo_empty ? 1'b0 : w_head[DATA_SIZE];
  assign rd_dbl_err   = fifo_empty ? 1'b0 : w_head[DATA_SIZE+1];

  // ---------------------------------------------------------------------------
  // Sticky flags and saturating counters
  // ---------------------------------------------------------------------------
  logic        overrun_q, frame_err_q, frag_err_q;
  logic [15:0] cnt_single_q, cnt_double_q;
  logic        w_ev_single, w_ev_double;

  assign w_ev_single = byte_done_q && w_corr;
  assign w_ev_double = byte_done_q && w_dbl;

  // Clearing loses to a same-cycle event so no event is ever missed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      frag_err_q   <= 1'b0;
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else if (clr_status) begin
      overrun_q    <= w_ovr_evt;
      frame_err_q  <= frame_evt_q;
      frag_err_q   <= w_frag_evt;
      cnt_single_q <= {15'd0, w_ev_single};
      cnt_double_q <= {15'd0, w_ev_double};
    end else begin
      if (w_ovr_evt)   overrun_q   <= 1'b1;
      if (frame_evt_q) frame_err_q <= 1'b1;
      if (w_frag_evt)  frag_err_q  <= 1'b1;
      if (w_ev_single && (cnt_single_q != 16'hFFFF)) cnt_single_q <= cnt_single_q + 16'd1;
      if (w_ev_double && (cnt_double_q != 16'hFFFF)) cnt_double_q <= cnt_double_q + 16'd1;
    end
  end

  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
  assign frag_err   = frag_err_q;
  assign cnt_single = cnt_single_q;
  assign cnt_double = cnt_double_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_secded_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_secded_rx_fifo                                          |
// | Purpose  : Scoreboard bench for uart_secded_rx_fifo with directed frames.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_secded_rx_fifo;

  localparam int DATA_SIZE  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int SYS_FREQ   = 3200000;
  localparam int BAUD_RATE  = 100000;
  localparam int SAMPLE     = 16;
  localparam int GAP_BITS   = 20;
  // (2*3.2M + 1.6M) / 3.2M rounds down to 2 clocks per tick -> 32 clocks per bit
  localparam int BIT_CLKS   = 32;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 rx = 1'b1;
  logic                 rd_en = 1'b0;
  logic                 clr_status = 1'b0;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_corrected, rd_dbl_err;
  logic                 fifo_empty, fifo_full;
  logic [4:0]           fifo_count;
  logic                 overrun, frame_err, frag_err;
  logic [15:0]          cnt_single, cnt_double;

  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  bit   auto_read   = 1'b0;
  bit   pop_on_push = 1'b0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  always #5 clk = ~clk;

  uart_secded_rx_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .SYS_FREQ  (SYS_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .SAMPLE    (SAMPLE),
    .LSN_FIRST (1),
    .GAP_BITS  (GAP_BITS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx          (rx),
    .rd_en       (rd_en),
    .clr_status  (clr_status),
    .rd_data     (rd_data),
    .rd_corrected(rd_corrected),
    .rd_dbl_err  (rd_dbl_err),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .frag_err    (frag_err),
    .cnt_single  (cnt_single),
    .cnt_double  (cnt_double)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] first, input logic [7:0] second);
    send_byte(first, 1'b1);
    send_byte(second, 1'b1);
  endtask

  task automatic expect_entry(input logic dbl, input logic corr, input logic [7:0] data);
    exp_q.push_back({dbl, corr, data});
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && (exp_q.size() != 0 || !fifo_empty); i++) @(negedge clk);
    check(name, {31'd0, (exp_q.size() == 0 && fifo_empty)}, 32'd1);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_rd_corrected", {31'd0, rd_corrected}, 32'd0);
    check("rst_rd_dbl_err", {31'd0, rd_dbl_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_frag_err", {31'd0, frag_err}, 32'd0);
    check("rst_cnt_single", {16'd0, cnt_single}, 32'd0);
    check("rst_cnt_double", {16'd0, cnt_double}, 32'd0);
  endtask

  // Monitor: pops whenever a head entry is available and reading is enabled,
  // comparing it against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      rd_en = 1'b0;
      if (!fifo_empty && (auto_read || (pop_on_push && dut.push_q))) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_entry: actual=%0h required=none",
                   {rd_dbl_err, rd_corrected, rd_data});
        end else begin
          mon_exp = exp_q.pop_front();
          check("entry", {22'd0, rd_dbl_err, rd_corrected, rd_data}, {22'd0, mon_exp});
        end
        rd_en = 1'b1;
        pops++;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values();
    auto_read = 1'b1;

    // Clean word: 0x66 -> nibble D, 0xE1 -> nibble C
    expect_entry(1'b0, 1'b0, 8'hCD);
    send_word(8'h66, 8'hE1);
    wait_drain("drain_clean");
    check("clean_cnt_single", {16'd0, cnt_single}, 32'd0);
    check("clean_cnt_double", {16'd0, cnt_double}, 32'd0);

    // Single data-bit error, then overall-parity-bit error
    expect_entry(1'b0, 1'b1, 8'hCD);
    send_word(8'h62, 8'hE1);
    expect_entry(1'b0, 1'b1, 8'hCD);
    send_word(8'hE6, 8'hE1);
    wait_drain("drain_single");
    check("single_cnt_single", {16'd0, cnt_single}, 32'd2);

    // Double error: raw nibble D kept, dbl flag set
    expect_entry(1'b1, 1'b0, 8'hCD);
    send_word(8'h65, 8'hE1);
    wait_drain("drain_double");
    check("double_cnt_double", {16'd0, cnt_double}, 32'd1);
    check("double_cnt_single", {16'd0, cnt_single}, 32'd2);

    // Framing error discards the byte, then recovery, then clear
    send_byte(8'h66, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    check("frame_err_set", {31'd0, frame_err}, 32'd1);
    check("frame_no_push", {31'd0, fifo_empty}, 32'd1);
    expect_entry(1'b0, 1'b0, 8'hCD);
    send_word(8'h66, 8'hE1);
    wait_drain("drain_frame_recover");
    pulse_clr();
    check("clr_frame_err", {31'd0, frame_err}, 32'd0);
    check("clr_cnt_single", {16'd0, cnt_single}, 32'd0);
    check("clr_cnt_double", {16'd0, cnt_double}, 32'd0);

    // Overflow: 17 words without reading, the last one is dropped
    auto_read = 1'b0;
    for (int w = 0; w < 17; w++) begin
      if (w < FIFO_DEPTH) expect_entry(1'b0, 1'b0, 8'hF0);
      send_word(8'h00, 8'hFF);
    end
    check("ovf_full", {31'd0, fifo_full}, 32'd1);
    check("ovf_count", {27'd0, fifo_count}, 32'd16);
    check("ovf_overrun", {31'd0, overrun}, 32'd1);
    pulse_clr();
    check("ovf_overrun_clr", {31'd0, overrun}, 32'd0);

    // Push and pop in the same cycle while full
    p0 = pops;
    pop_on_push = 1'b1;
    expect_entry(1'b0, 1'b0, 8'hF0);
    send_word(8'h00, 8'hFF);
    for (int i = 0; i < 500 && pops == p0; i++) @(negedge clk);
    pop_on_push = 1'b0;
    check("pushpop_seen", pops - p0, 32'd1);
    check("pushpop_count", {27'd0, fifo_count}, 32'd16);
    check("pushpop_no_overrun", {31'd0, overrun}, 32'd0);
    auto_read = 1'b1;
    wait_drain("drain_overflow");
    check("ovf_drained_count", {27'd0, fifo_count}, 32'd0);

    // Gap timeout discards the half word
    send_byte(8'h66, 1'b1);
    repeat (24 * BIT_CLKS) @(negedge clk);
    check("gap_frag_err", {31'd0, frag_err}, 32'd1);
    check("gap_no_push", {31'd0, fifo_empty}, 32'd1);
    expect_entry(1'b0, 1'b0, 8'hF0);
    send_word(8'h00, 8'hFF);
    wait_drain("drain_gap_recover");

    // Reset mid-byte with a stored entry and sticky flag set
    auto_read = 1'b0;
    send_word(8'h66, 8'hE1);
    check("pre_reset_count", {27'd0, fifo_count}, 32'd1);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (BIT_CLKS * 3) @(negedge clk);
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;
    auto_read = 1'b1;
    repeat (30 * BIT_CLKS) @(negedge clk);
    check("post_reset_empty", {31'd0, fifo_empty}, 32'd1);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
